// File: rtl/instr_sequencer.sv
// Multi-cycle fetch/decode/execute controller for the 16-bit single-bus CPU.
// Owns PC, IR and the retired-instruction counter; fetches over a req/ack
// port, turns the decoder control word into qualified strobes and resolves
// jumps/branches. All outputs come from registers or from state decode.
module instr_sequencer #(
    parameter int          PC_W    = 16,
    parameter logic [15:0] HALT_OP = 16'hFFFF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [15:0]     imem_rdata,
    output logic [15:0]     ir,
    input  logic [19:0]     ctl_in,
    input  logic            z_flag,
    input  logic            n_flag,
    input  logic [PC_W-1:0] ra_value,
    output logic            rw_en,
    output logic            dmem_we,
    input  logic            dmem_ack,
    output logic [PC_W-1:0] pc,
    output logic [15:0]     retired,
    output logic            halted
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEMWAIT,
        S_HALTED
    } state_t;

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [15:0]     ir_q, ir_d;
    logic [15:0]     retired_q, retired_d;
    logic            rw_en_q, rw_en_d;

    // Control-word fields consumed by the sequencer.
    logic ctl_rw, ctl_mw, ctl_pl, ctl_jb, ctl_bc;
    assign ctl_rw = ctl_in[4];
    assign ctl_mw = ctl_in[3];
    assign ctl_pl = ctl_in[2];
    assign ctl_jb = ctl_in[1];
    assign ctl_bc = ctl_in[0];

    // Upper control bits drive the datapath, not this block.
    logic ctl_unused;
    assign ctl_unused = ^ctl_in[19:5];

    // Branch offset: 6-bit two's complement split across IR fields.
    logic [5:0]      ad;
    logic [PC_W-1:0] br_off;
    logic [PC_W-1:0] pc_inc;
    logic            is_halt;
    logic            br_taken;

    assign ad       = {ir_q[8:6], ir_q[2:0]};
    assign br_off   = {{(PC_W-6){ad[5]}}, ad};
    assign pc_inc   = pc_q + PC_W'(1);
    assign is_halt  = (ir_q == HALT_OP);
    assign br_taken = ctl_bc ? n_flag : z_flag;

    // Next-state, PC/IR/counter updates and the registered write strobe.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        retired_d = retired_q;
        rw_en_d   = 1'b0;
        case (state_q)
            S_IDLE, S_HALTED: begin
                if (start) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                if (imem_ack) begin
                    ir_d    = imem_rdata;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                // The strobe is armed here so that it is high for exactly
                // the EXEC cycle while remaining a plain register output.
                // Stores, control transfers and halt never write.
                rw_en_d = ctl_rw & ~ctl_mw & ~ctl_pl & ~is_halt;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                if (is_halt) begin
                    pc_d      = pc_inc;
                    retired_d = retired_q + 16'd1;
                    state_d   = S_HALTED;
                end else if (ctl_mw) begin
                    // Store has priority over any PL bit; PC advances on ack.
                    state_d = S_MEMWAIT;
                end else begin
                    if (ctl_pl && ctl_jb) begin
                        pc_d = ra_value;
                    end else if (ctl_pl) begin
                        pc_d = br_taken ? (pc_q + br_off) : pc_inc;
                    end else begin
                        pc_d = pc_inc;
                    end
                    retired_d = retired_q + 16'd1;
                    state_d   = S_FETCH;
                end
            end
            S_MEMWAIT: begin
                if (dmem_ack) begin
                    pc_d      = pc_inc;
                    retired_d = retired_q + 16'd1;
                    state_d   = S_FETCH;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State register; reset wins over any in-flight request or ack.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            pc_q      <= '0;
            ir_q      <= '0;
            retired_q <= '0;
            rw_en_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            retired_q <= retired_d;
            rw_en_q   <= rw_en_d;
        end
    end

    assign imem_req  = (state_q == S_FETCH);
    assign imem_addr = pc_q;
    assign dmem_we   = (state_q == S_MEMWAIT);
    assign halted    = (state_q == S_HALTED);
    assign rw_en     = rw_en_q;
    assign ir        = ir_q;
    assign pc        = pc_q;
    assign retired   = retired_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: the bench plays instruction memory,
// decoder and datapath flags, and checks strobes, PC and counters against
// hand-computed values.
module tb_instr_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic [15:0] ir;
    logic [19:0] ctl_in;
    logic        z_flag;
    logic        n_flag;
    logic [15:0] ra_value;
    logic        rw_en;
    logic        dmem_we;
    logic        dmem_ack;
    logic [15:0] pc;
    logic [15:0] retired;
    logic        halted;

    int          n_asserts = 0;
    int          n_fails   = 0;
    logic [15:0] cur_pc;
    logic [15:0] exp_retired;
    int          last_req_cycles;

    // Control words as the decoder would present them.
    localparam logic [19:0] C_NONE  = 20'h00000;
    localparam logic [19:0] C_RW    = 20'h00010;
    localparam logic [19:0] C_BZ    = 20'h00004;
    localparam logic [19:0] C_BN    = 20'h00005;
    localparam logic [19:0] C_JMP   = 20'h00016;  // RW also set: must not write
    localparam logic [19:0] C_STORE = 20'h00018;  // RW also set: must not write

    instr_sequencer #(.PC_W(16), .HALT_OP(16'hFFFF)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .ir         (ir),
        .ctl_in     (ctl_in),
        .z_flag     (z_flag),
        .n_flag     (n_flag),
        .ra_value   (ra_value),
        .rw_en      (rw_en),
        .dmem_we    (dmem_we),
        .dmem_ack   (dmem_ack),
        .pc         (pc),
        .retired    (retired),
        .halted     (halted)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_asserts++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_imem_req"}, imem_req, 0);
        check({tag, "_rw_en"},    rw_en,    0);
        check({tag, "_dmem_we"},  dmem_we,  0);
        check({tag, "_halted"},   halted,   0);
        check({tag, "_pc"},       pc,       0);
        check({tag, "_ir"},       ir,       0);
        check({tag, "_retired"},  retired,  0);
    endtask

    // Serve one fetch at cur_pc; returns at the negedge with the DUT in DECODE.
    task automatic fetch(input string tag, input logic [15:0] instr, input logic [19:0] ctl,
                         input int waits);
        int guard;
        guard = 0;
        while (!imem_req && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check({tag, "_req"},  imem_req,  1);
        check({tag, "_addr"}, imem_addr, cur_pc);
        last_req_cycles = 0;
        for (int i = 0; i < waits; i++) begin
            last_req_cycles += int'(imem_req);
            @(negedge clk);
        end
        last_req_cycles += int'(imem_req);
        imem_ack   = 1'b1;
        imem_rdata = instr;
        ctl_in     = ctl;
        @(negedge clk);
        imem_ack   = 1'b0;
        imem_rdata = 16'hDEAD;
    endtask

    // One complete non-store instruction: fetch, decode, exec, then check.
    task automatic step(input string tag, input logic [15:0] instr, input logic [19:0] ctl,
                        input int waits, input logic zf, input logic nf, input logic [15:0] ra,
                        input int exp_rw, input logic [15:0] exp_pc);
        int rwc;
        z_flag   = zf;
        n_flag   = nf;
        ra_value = ra;
        fetch(tag, instr, ctl, waits);
        rwc = int'(rw_en);
        check({tag, "_req_drop"}, imem_req, 0);
        check({tag, "_ir"}, ir, instr);
        @(negedge clk);
        rwc += int'(rw_en);
        @(negedge clk);
        rwc += int'(rw_en);
        exp_retired = exp_retired + 16'd1;
        check({tag, "_rw_pulses"}, rwc, exp_rw);
        check({tag, "_pc"}, pc, exp_pc);
        check({tag, "_retired"}, retired, exp_retired);
        cur_pc = exp_pc;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        int wec;
        int rwc;
        rst = 1'b1; start = 1'b0; imem_ack = 1'b0; imem_rdata = 16'h0;
        ctl_in = C_NONE; z_flag = 1'b0; n_flag = 1'b0; ra_value = 16'h0; dmem_ack = 1'b0;
        cur_pc = 16'h0; exp_retired = 16'h0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);
        check("idle_no_req", imem_req, 0);

        // First instruction: two wait states, register write.
        pulse_start();
        step("alu0", 16'h0000, C_RW, 2, 1'b0, 1'b0, 16'h0, 1, 16'h0001);
        check("alu0_req_cycles", last_req_cycles, 3);

        // Walk forward to pc=5 with non-writing ALU ops.
        step("alu1", 16'h0001, C_NONE, 0, 1'b0, 1'b0, 16'h0, 0, 16'h0002);
        step("alu2", 16'h0002, C_NONE, 1, 1'b0, 1'b0, 16'h0, 0, 16'h0003);
        step("alu3", 16'h0003, C_NONE, 0, 1'b0, 1'b0, 16'h0, 0, 16'h0004);
        step("alu4", 16'h0004, C_NONE, 0, 1'b0, 1'b0, 16'h0, 0, 16'h0005);

        // Branches with ad = -2 (ir[8:6]=111, ir[2:0]=110).
        step("bz_taken", 16'h01C6, C_BZ, 0, 1'b1, 1'b0, 16'h0, 0, 16'h0003);
        step("alu5",     16'h0005, C_NONE, 0, 1'b0, 1'b0, 16'h0, 0, 16'h0004);
        step("alu6",     16'h0006, C_NONE, 0, 1'b0, 1'b0, 16'h0, 0, 16'h0005);
        step("bz_not",   16'h01C6, C_BZ, 0, 1'b0, 1'b1, 16'h0, 0, 16'h0006);
        step("bn_taken", 16'h01C6, C_BN, 0, 1'b0, 1'b1, 16'h0, 0, 16'h0004);
        step("alu7",     16'h0007, C_NONE, 0, 1'b0, 1'b0, 16'h0, 0, 16'h0005);
        step("bn_not",   16'h01C6, C_BN, 0, 1'b1, 1'b0, 16'h0, 0, 16'h0006);

        // Jump to the register A value.
        step("jmp", 16'h0100, C_JMP, 0, 1'b0, 1'b0, 16'h00A0, 0, 16'h00A0);

        // Store with dmem_ack on the fourth MEMWAIT cycle; a stray imem_ack
        // during MEMWAIT must not touch IR.
        fetch("st", 16'h4000, C_STORE, 0);
        rwc = int'(rw_en);
        @(negedge clk);
        rwc += int'(rw_en);
        check("st_exec_pc", pc, 16'h00A0);
        @(negedge clk);
        wec = 0;
        imem_ack   = 1'b1;
        imem_rdata = 16'hBEEF;
        for (int k = 0; k < 4; k++) begin
            wec += int'(dmem_we);
            rwc += int'(rw_en);
            if (k == 1) imem_ack = 1'b0;
            if (k == 3) dmem_ack = 1'b1;
            @(negedge clk);
        end
        dmem_ack = 1'b0;
        rwc += int'(rw_en);
        exp_retired = exp_retired + 16'd1;
        check("st_we_cycles", wec, 4);
        check("st_we_dropped", dmem_we, 0);
        check("st_rw_pulses", rwc, 0);
        check("st_ir_kept", ir, 16'h4000);
        check("st_pc", pc, 16'h00A1);
        check("st_retired", retired, exp_retired);
        check("st_refetch", imem_req, 1);
        cur_pc = 16'h00A1;

        // PC wrap in both directions.
        step("jmp_max",  16'h0100, C_JMP, 0, 1'b0, 1'b0, 16'hFFFF, 0, 16'hFFFF);
        step("wrap_inc", 16'h0008, C_NONE, 0, 1'b0, 1'b0, 16'h0, 0, 16'h0000);
        step("wrap_dec", 16'h01C7, C_BZ, 0, 1'b1, 1'b0, 16'h0, 0, 16'hFFFF);
        step("jmp_9",    16'h0100, C_JMP, 0, 1'b0, 1'b0, 16'h0009, 0, 16'h0009);

        // Halt at pc=9, then resume at 10; a start pulse mid-FETCH is ignored.
        step("halt", 16'hFFFF, C_RW, 0, 1'b0, 1'b0, 16'h0, 0, 16'h000A);
        check("halt_flag", halted, 1);
        check("halt_no_req", imem_req, 0);
        repeat (2) @(negedge clk);
        check("halt_stays", halted, 1);
        check("halt_pc_hold", pc, 16'h000A);
        pulse_start();
        check("resume_unhalt", halted, 0);
        pulse_start();
        check("mid_start_req", imem_req, 1);
        check("mid_start_addr", imem_addr, 16'h000A);
        step("resume_alu", 16'h0009, C_RW, 0, 1'b0, 1'b0, 16'h0, 1, 16'h000B);

        // Reset while a store waits for its ack.
        fetch("rst_st", 16'h4001, C_STORE, 0);
        @(negedge clk);
        @(negedge clk);
        check("rst_st_we", dmem_we, 1);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("rst_memwait");
        rst = 1'b0;
        @(negedge clk);
        check("rst_memwait_idle", imem_req, 0);
        cur_pc = 16'h0;
        exp_retired = 16'h0;

        // Reset in FETCH with the ack landing on the reset edge.
        pulse_start();
        check("rst_fetch_req", imem_req, 1);
        rst        = 1'b1;
        imem_ack   = 1'b1;
        imem_rdata = 16'h1234;
        @(negedge clk);
        imem_ack = 1'b0;
        rst      = 1'b0;
        check_reset_outputs("rst_fetch");
        @(negedge clk);
        check("rst_fetch_idle", imem_req, 0);
        check("rst_fetch_ir", ir, 16'h0000);

        pulse_start();
        step("post_rst", 16'h0002, C_NONE, 0, 1'b0, 1'b0, 16'h0, 0, 16'h0001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

endmodule
